// File: rtl/trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture_ctrl
//  Description : Ring-buffer capture into a trace BRAM up to a trigger plus a
//                post-trigger window, then oldest-first readout on valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              trace_valid,
    input  logic [DATA_W-1:0] trace_data,
    input  logic              trigger,
    input  logic              read_start,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              armed,
    output logic              done,
    output logic              wrapped
);

    localparam logic [ADDR_W-1:0] c_ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_PTR_MAX   = '1;
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_DEPTH     = {1'b1, c_ADDR_ZERO};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_accept;
    logic                w_hs;
    logic                w_cnt_last;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_post;
    logic [ADDR_W-1:0]   r_remaining;
    logic [ADDR_W:0]     r_rd_cnt;
    logic                r_wrapped;
    logic                r_dout_valid;
    logic                r_fetch;

    assign w_hs       = r_dout_valid & dout_ready;
    assign w_cnt_last = (r_rd_cnt == c_CNT_ONE);

    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign rd_addr    = r_rd_addr;
    assign dout       = rd_data;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_valid & w_cnt_last;
    assign armed      = (r_state == S_ARMED) || (r_state == S_POST);
    assign done       = (r_state == S_DONE);
    assign wrapped    = r_wrapped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (trace_valid) begin
                    w_accept = 1'b1;
                    if (trigger) begin
                        w_state_nx = (r_post == c_ADDR_ZERO) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (trace_valid) begin
                    w_accept = 1'b1;
                    if (r_remaining == c_ADDR_ONE) begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (read_start) begin
                    w_state_nx = S_READ;
                end
            end
            S_READ: begin
                if (w_hs && w_cnt_last) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (abort) begin
            w_state_nx = S_IDLE;
            w_accept   = 1'b0;
        end
    end

    // BRAM address/data registers hold across abort so the idle rewrite stays harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_addr    <= '0;
            r_post       <= '0;
            r_remaining  <= '0;
            r_rd_cnt     <= '0;
            r_wrapped    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_fetch      <= 1'b0;
        end else if (abort) begin
            r_wr_ptr     <= '0;
            r_remaining  <= '0;
            r_rd_cnt     <= '0;
            r_wrapped    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_fetch      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && arm) begin
                r_wr_ptr  <= '0;
                r_wrapped <= 1'b0;
                r_post    <= post_count;
            end
            if (w_accept) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= trace_data;
                r_wr_ptr  <= r_wr_ptr + c_ADDR_ONE;
                if (r_wr_ptr == c_PTR_MAX) begin
                    r_wrapped <= 1'b1;
                end
                if (r_state == S_ARMED && trigger) begin
                    r_remaining <= r_post;
                end
                if (r_state == S_POST) begin
                    r_remaining <= r_remaining - c_ADDR_ONE;
                end
            end
            if (r_state == S_DONE && read_start) begin
                r_rd_addr <= r_wrapped ? r_wr_ptr : c_ADDR_ZERO;
                r_rd_cnt  <= r_wrapped ? c_DEPTH : {1'b0, r_wr_ptr};
                r_fetch   <= 1'b1;
            end
            // r_fetch marks the cycle the BRAM is still producing the word at rd_addr.
            if (r_state == S_READ) begin
                if (r_fetch) begin
                    r_dout_valid <= 1'b1;
                    r_fetch      <= 1'b0;
                end
                if (w_hs) begin
                    r_dout_valid <= 1'b0;
                    r_rd_addr    <= r_rd_addr + c_ADDR_ONE;
                    r_rd_cnt     <= r_rd_cnt - c_CNT_ONE;
                    r_fetch      <= !w_cnt_last;
                end
            end
        end
    end

endmodule
`default_nettype wire
